// File: rtl/chs_pkg.sv
// Shared definitions for the chassis power-ramp controller: FSM state
// encoding and the ceiling-log2 helper used to size counters and datapaths.
package chs_pkg;

  typedef enum logic [1:0] {
    CHS_IDLE  = 2'd0,
    CHS_COUNT = 2'd1,
    CHS_RAMP  = 2'd2
  } chs_state_e;

  // Smallest width able to index 'value' distinct items (ceil(log2(value))).
  function automatic int chs_clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/chs_popcount_chunk.sv
// Combinational ones counter for one CHUNK-bit slice of the configuration word.
module chs_popcount_chunk
  import chs_pkg::*;
#(
  parameter int CHUNK = 2,
  localparam int CNT_W = chs_clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [CNT_W-1:0] count
);

  // NOTE: every always_comb output gets a default before any branch or loop so no latch is inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/chs_power_ramp.sv
// Chassis power ramp: counts the ones of a configuration word CHUNK bits per
// cycle, then slews power/mode toward the result. Define CHS_HYST_EN to skip
// the ramp when the new target lies within HYST of the present power.
module chs_power_ramp
  import chs_pkg::*;
#(
  parameter int CONF_W = 8,
  parameter int CHUNK  = 2,
  parameter int STEP   = 1,
  parameter int HYST   = 1,
  localparam int POW_W = chs_clog2(CONF_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chs_conf_valid,
  input  logic [CONF_W-1:0] chs_conf,
  output logic              chs_conf_ready,
  output logic [POW_W-1:0]  chs_power,
  output logic              chs_mode,
  output logic              chs_busy,
  output logic              chs_done
);

  localparam int NCHUNK = CONF_W / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? chs_clog2(NCHUNK) : 1;
  localparam int CNT_W  = chs_clog2(CHUNK + 1);
  localparam logic [POW_W-1:0] STEP_P   = POW_W'((STEP > CONF_W) ? CONF_W : STEP);
  localparam logic [POW_W-1:0] HYST_P   = POW_W'((HYST > CONF_W) ? CONF_W : HYST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

`ifdef CHS_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  chs_state_e        state_q, state_d;
  logic [CONF_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [POW_W-1:0]  acc_q, acc_d;
  logic [POW_W-1:0]  tgt_pow_q, tgt_pow_d;
  logic [POW_W-1:0]  power_q, power_d;
  logic              tgt_mode_q, tgt_mode_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  chunk_ones;
  logic [POW_W-1:0]  acc_sum;
  logic [POW_W-1:0]  hyst_gap;
  logic [POW_W-1:0]  gap;
  logic [POW_W-1:0]  step_amt;
  logic              hyst_hit;

  chs_popcount_chunk #(.CHUNK(CHUNK)) u_popcount (
    .bits  (shift_q[CHUNK-1:0]),
    .count (chunk_ones)
  );

  assign acc_sum  = acc_q + POW_W'(chunk_ones);
  assign hyst_gap = (acc_sum >= power_q) ? acc_sum - power_q : power_q - acc_sum;
  // Same-mode target close enough to the present power counts as already reached.
  assign hyst_hit = HYST_ON && (tgt_mode_q == mode_q) && (hyst_gap <= HYST_P);
  assign gap      = (tgt_pow_q >= power_q) ? tgt_pow_q - power_q : power_q - tgt_pow_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    tgt_pow_d  = tgt_pow_q;
    tgt_mode_d = tgt_mode_q;
    power_d    = power_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    step_amt   = '0;

    unique case (state_q)
      CHS_IDLE: begin
        if (chs_conf_valid) begin
          shift_d    = chs_conf;
          tgt_mode_d = chs_conf[0];
          acc_d      = '0;
          idx_d      = '0;
          state_d    = CHS_COUNT;
        end
      end

      CHS_COUNT: begin
        acc_d   = acc_sum;
        shift_d = shift_q >> CHUNK;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          tgt_pow_d = acc_sum;
          if (hyst_hit) begin
            state_d = CHS_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = CHS_RAMP;
          end
        end
      end

      CHS_RAMP: begin
        // A heat/cool swap must first drain power to zero, then flip mode on its own edge.
        if (tgt_mode_q != mode_q) begin
          if (power_q != '0) begin
            step_amt = (power_q < STEP_P) ? power_q : STEP_P;
            power_d  = power_q - step_amt;
          end else begin
            mode_d = tgt_mode_q;
          end
        end else begin
          step_amt = (gap < STEP_P) ? gap : STEP_P;
          power_d  = (tgt_pow_q >= power_q) ? power_q + step_amt : power_q - step_amt;
        end
        if ((power_d == tgt_pow_q) && (mode_d == tgt_mode_q)) begin
          state_d = CHS_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = CHS_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CHS_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      tgt_pow_q  <= '0;
      tgt_mode_q <= 1'b0;
      power_q    <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      tgt_pow_q  <= tgt_pow_d;
      tgt_mode_q <= tgt_mode_d;
      power_q    <= power_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
    end
  end

  assign chs_conf_ready = (state_q == CHS_IDLE);
  assign chs_busy       = (state_q != CHS_IDLE);
  assign chs_power      = power_q;
  assign chs_mode       = mode_q;
  assign chs_done       = done_q;

endmodule
